// File: rtl/wu_fetch_mc.sv
`default_nettype none
// ============================================================================
// Module      : wu_fetch_mc
// Description : Multi-context WU fetch. Per-context PCs, round-robin issue,
//               tagged return FIFO with credit flow control to WU decode.
// Revision    : 1.0 - initial release
// ============================================================================
module wu_fetch_mc #(
  parameter int NUM_CTX    = 4,
  parameter int ADDR_W     = 10,
  parameter int WORD_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_CTX-1:0]        mcntl__wuf__enable,
  input  logic [NUM_CTX-1:0]        mcntl__wuf__start_valid,
  input  logic [NUM_CTX*ADDR_W-1:0] mcntl__wuf__start_addr,
  input  logic [NUM_CTX-1:0]        xxx__wuf__stall,
  output logic                      wuf__wum__read,
  output logic [ADDR_W-1:0]         wuf__wum__addr,
  input  logic                      wum__wuf__valid,
  input  logic [WORD_W-1:0]         wum__wuf__data,
  input  logic [1:0]                wum__wuf__icntl,
  output logic                      wuf__wud__valid,
  input  logic                      wud__wuf__ready,
  output logic [WORD_W-1:0]         wuf__wud__data,
  output logic [1:0]                wuf__wud__icntl,
  output logic [CTX_W-1:0]          wuf__wud__ctxId,
  output logic [NUM_CTX-1:0]        wuf__mcntl__ctx_busy,
  output logic                      wuf__sys__error
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0]  r_pc [NUM_CTX];
  logic [CTX_W-1:0]   r_last;
  logic [c_cnt_w-1:0] r_used;
  logic               r_read;
  logic [ADDR_W-1:0]  r_addr;
  logic [CTX_W-1:0]   r_read_ctx;
  logic [MEM_LAT-1:0] r_tag_vld;
  logic [CTX_W-1:0]   r_tag_ctx [MEM_LAT];
  logic               r_err;

  logic [WORD_W-1:0]  r_fdata [FIFO_DEPTH];
  logic [1:0]         r_fcntl [FIFO_DEPTH];
  logic [CTX_W-1:0]   r_fctx  [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr;
  logic [c_ptr_w-1:0] r_rd;
  logic [c_cnt_w-1:0] r_occ;
  logic [c_cnt_w-1:0] r_inf  [NUM_CTX];
  logic [c_cnt_w-1:0] r_fcnt [NUM_CTX];

  logic               w_credit;
  logic [NUM_CTX-1:0] w_elig;
  logic               w_grant_vld;
  logic [CTX_W-1:0]   w_grant;
  logic               w_tag_hit;
  logic [CTX_W-1:0]   w_tag_ctx;
  logic               w_push;
  logic               w_lost;
  logic               w_pop;
  logic               w_head_vld;
  logic [CTX_W-1:0]   w_head_ctx;

  // r_used tracks FIFO occupancy plus every read not yet returned
  assign w_credit   = (r_used < c_cnt_w'(FIFO_DEPTH));
  assign w_elig     = mcntl__wuf__enable & ~xxx__wuf__stall & ~mcntl__wuf__start_valid
                      & {NUM_CTX{w_credit}};
  assign w_tag_hit  = r_tag_vld[MEM_LAT-1];
  assign w_tag_ctx  = r_tag_ctx[MEM_LAT-1];
  assign w_push     = wum__wuf__valid & w_tag_hit;
  assign w_lost     = w_tag_hit & ~wum__wuf__valid;
  assign w_head_vld = (r_occ != '0);
  assign w_head_ctx = r_fctx[r_rd];
  assign w_pop      = w_head_vld & wud__wuf__ready;

  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = 1; k <= NUM_CTX; k++) begin
      idx = (int'(r_last) + k) % NUM_CTX;
      if (!w_grant_vld && w_elig[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = CTX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_last     <= CTX_W'(NUM_CTX - 1);
      r_used     <= '0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_read_ctx <= '0;
      r_tag_vld  <= '0;
      r_err      <= 1'b0;
      for (int j = 0; j < MEM_LAT; j++) r_tag_ctx[j] <= '0;
    end else begin
      r_used     <= r_used + c_cnt_w'(w_grant_vld) - c_cnt_w'(w_pop) - c_cnt_w'(w_lost);
      r_read     <= w_grant_vld;
      r_read_ctx <= w_grant;
      if (w_grant_vld) begin
        r_last <= w_grant;
        r_addr <= r_pc[w_grant];
      end
      r_tag_vld[0] <= r_read;
      r_tag_ctx[0] <= r_read_ctx;
      for (int j = 1; j < MEM_LAT; j++) begin
        r_tag_vld[j] <= r_tag_vld[j-1];
        r_tag_ctx[j] <= r_tag_ctx[j-1];
      end
      if (wum__wuf__valid && !w_tag_hit) r_err <= 1'b1;
    end
  end

  // Load beats issue for the same context; eligibility already excludes it
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        r_pc[i]   <= '0;
        r_inf[i]  <= '0;
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (mcntl__wuf__start_valid[i])
          r_pc[i] <= mcntl__wuf__start_addr[i*ADDR_W +: ADDR_W];
        else if (w_grant_vld && (w_grant == CTX_W'(i)))
          r_pc[i] <= r_pc[i] + 1'b1;
        r_inf[i]  <= r_inf[i]
                     + c_cnt_w'(w_grant_vld && (w_grant == CTX_W'(i)))
                     - c_cnt_w'(w_tag_hit && (w_tag_ctx == CTX_W'(i)));
        r_fcnt[i] <= r_fcnt[i]
                     + c_cnt_w'(w_push && (w_tag_ctx == CTX_W'(i)))
                     - c_cnt_w'(w_pop && (w_head_ctx == CTX_W'(i)));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_occ <= r_occ + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fdata[r_wr] <= wum__wuf__data;
      r_fcntl[r_wr] <= wum__wuf__icntl;
      r_fctx[r_wr]  <= w_tag_ctx;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CTX; i++) begin : g_busy
      assign wuf__mcntl__ctx_busy[i] = mcntl__wuf__enable[i] | (r_inf[i] != '0)
                                       | (r_fcnt[i] != '0);
    end
  endgenerate

  assign wuf__wum__read  = r_read;
  assign wuf__wum__addr  = r_addr;
  assign wuf__wud__valid = w_head_vld;
  assign wuf__wud__data  = w_head_vld ? r_fdata[r_rd] : '0;
  assign wuf__wud__icntl = w_head_vld ? r_fcntl[r_rd] : 2'b00;
  assign wuf__wud__ctxId = w_head_vld ? w_head_ctx : '0;
  assign wuf__sys__error = r_err;

endmodule
`default_nettype wire
